// File: rtl/pe_drain_if.sv
// Row-drain bus: skewed column results in, realigned requantised rows out.
// Master drives results and ready; slave (pe_drain) returns rows and FIFO status.
interface pe_drain_if #(
    parameter int unsigned COLS   = 4,
    parameter int unsigned ACC_BW = 32,
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic                     in_valid_i;
    logic [COLS*ACC_BW-1:0]   o_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [COLS*MUL_BW-1:0]   out_data_o;
    logic [LW-1:0]            level_o;
    logic                     ovf_o;

    modport master (
        output in_valid_i, o_i, out_ready_i,
        input  out_valid_o, out_data_o, level_o, ovf_o
    );

    modport slave (
        input  in_valid_i, o_i, out_ready_i,
        output out_valid_o, out_data_o, level_o, ovf_o
    );
endinterface

// File: rtl/pe_drain.sv
// Systolic array output drain: deskew columns, requantise with saturation, buffer rows in a FIFO.
// Optional PE_DRAIN_ROUND_EN: round half up before the requantising shift instead of truncating.
module pe_drain #(
    parameter int unsigned INT_BW = 5,
    parameter int unsigned FRA_BW = 10,
    parameter int unsigned MUL_BW = 16,
    parameter int unsigned ACC_BW = 32,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    pe_drain_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = ACC_BW + 1;
    localparam int unsigned RW = COLS * MUL_BW;

    localparam logic signed [SW-1:0] Q_MAX = SW'((longint'(1) <<< (INT_BW + FRA_BW)) - longint'(1));
    localparam logic signed [SW-1:0] Q_MIN = SW'(-(longint'(1) <<< (INT_BW + FRA_BW)));
`ifdef PE_DRAIN_ROUND_EN
    localparam logic signed [SW-1:0] RND   = SW'(longint'(1) <<< (FRA_BW - 1));
`endif

    // Drop 2*FRA_BW-fraction value to FRA_BW fraction; guard bit keeps the rounding add from wrapping.
    function automatic logic [MUL_BW-1:0] requant(input logic [ACC_BW-1:0] v);
        logic signed [SW-1:0] wide;
        logic signed [SW-1:0] shf;
        wide = $signed({v[ACC_BW-1], v});
`ifdef PE_DRAIN_ROUND_EN
        wide = wide + RND;
`endif
        shf = wide >>> FRA_BW;
        if (shf > Q_MAX)
            requant = Q_MAX[MUL_BW-1:0];
        else if (shf < Q_MIN)
            requant = Q_MIN[MUL_BW-1:0];
        else
            requant = shf[MUL_BW-1:0];
    endfunction

    logic [ACC_BW-1:0] aligned [COLS];
    logic              aligned_v;

    // Column c is delayed COLS-1-c cycles so all columns of a row line up.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned DLY = COLS - 1 - c;
        if (DLY == 0) begin : g_nodly
            assign aligned[c] = bus.o_i[c*ACC_BW +: ACC_BW];
        end else begin : g_dly
            logic [ACC_BW-1:0] pipe [DLY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DLY); i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= bus.o_i[c*ACC_BW +: ACC_BW];
                    for (int i = 1; i < int'(DLY); i++) pipe[i] <= pipe[i-1];
                end
            end
            assign aligned[c] = pipe[DLY-1];
        end
    end

    if (COLS == 1) begin : g_v_nodly
        assign aligned_v = bus.in_valid_i;
    end else begin : g_v_dly
        logic [COLS-2:0] vpipe;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                vpipe <= '0;
            else if (clr_i)
                vpipe <= '0;
            else
                vpipe <= (vpipe << 1) | (COLS-1)'(bus.in_valid_i);
        end
        assign aligned_v = vpipe[COLS-2];
    end

    logic [RW-1:0] quant_c;

    always_comb begin
        quant_c = '0;
        for (int c = 0; c < int'(COLS); c++)
            quant_c[c*MUL_BW +: MUL_BW] = requant(aligned[c]);
    end

    logic          sat_v;
    logic [RW-1:0] sat_row;

    // Saturation stage: only the valid bit is flushed by clr_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_v   <= 1'b0;
            sat_row <= '0;
        end else begin
            sat_v   <= clr_i ? 1'b0 : aligned_v;
            sat_row <= quant_c;
        end
    end

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          out_valid;
    logic          ovf;
    logic [RW-1:0] out_data;

    logic          pop_c;
    logic          full_c;
    logic          wr_en_c;
    logic          drop_c;
    logic [AW-1:0] rd_nxt_c;
    logic [LW-1:0] level_nxt_c;
    logic [RW-1:0] head_nxt_c;

    always_comb begin
        pop_c       = out_valid & bus.out_ready_i;
        full_c      = (level == LW'(DEPTH));
        wr_en_c     = sat_v & (~full_c | pop_c);
        drop_c      = sat_v & full_c & ~pop_c;
        rd_nxt_c    = rd_ptr + AW'(pop_c);
        level_nxt_c = level + LW'(wr_en_c) - LW'(pop_c);
        // Incoming row becomes the head when the FIFO would otherwise be empty.
        if (wr_en_c && (wr_ptr == rd_nxt_c))
            head_nxt_c = sat_row;
        else
            head_nxt_c = mem[rd_nxt_c];
    end

    always_ff @(posedge clk) begin
        if (wr_en_c && !clr_i)
            mem[wr_ptr] <= sat_row;
    end

    // FIFO control plus registered head word; clr_i overrides any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            out_data  <= '0;
        end else if (clr_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(wr_en_c);
            rd_ptr    <= rd_nxt_c;
            level     <= level_nxt_c;
            out_valid <= (level_nxt_c != '0);
            if (level_nxt_c != '0)
                out_data <= head_nxt_c;
            if (drop_c)
                ovf <= 1'b1;
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_data;
    assign bus.level_o     = level;
    assign bus.ovf_o       = ovf;
endmodule
